// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between the FIFO read port, fifo_stream_reader and its downstream consumer.
// The master modport is the reader block; the slave modport is its environment.
interface fifo_stream_reader_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                  en;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_read;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic [CNT_WIDTH-1:0]  pkt_count;

  modport master (
    input  en, fifo_empty, fifo_data, out_ready,
    output fifo_read, out_valid, out_data, out_last, pkt_count
  );

  modport slave (
    output en, fifo_empty, fifo_data, out_ready,
    input  fifo_read, out_valid, out_data, out_last, pkt_count
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a one-cycle-latency FIFO into a valid/ready stream through a 2-entry buffer,
// marking every PKT_LEN-th word with out_last and counting completed packets.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PKT_LEN    = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                clk,
  input  logic                rst,
  fifo_stream_reader_if.master bus
);
  localparam int unsigned BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            occ;
  logic                  infl;
  logic [BW-1:0]         beat;
  logic [CNT_WIDTH-1:0]  pkt_cnt;

  logic valid;
  logic last;
  logic pop;
  logic room;
  logic rd_req;

  // A read is only issued if the word it returns is guaranteed a buffer slot,
  // counting the word already in flight and any slot freed by this cycle's pop.
  always_comb begin
    valid  = (occ != 2'd0);
    last   = valid & (beat == LAST_BEAT);
    pop    = valid & bus.out_ready;
    room   = ({1'b0, occ} + {2'b0, infl}) < (3'd2 + {2'b0, pop});
    rd_req = rst & bus.en & ~bus.fifo_empty & room;
  end

  assign bus.fifo_read = rd_req;
  assign bus.out_valid = valid;
  assign bus.out_data  = mem[rd_ptr];
  assign bus.out_last  = last;
  assign bus.pkt_count = pkt_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      occ     <= '0;
      infl    <= 1'b0;
      beat    <= '0;
      pkt_cnt <= '0;
    end else begin
      infl <= rd_req;
      occ  <= occ + {1'b0, infl} - {1'b0, pop};
      if (infl) begin
        mem[wr_ptr] <= bus.fifo_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        beat   <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
        if (last) pkt_cnt <= pkt_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model, stream model of expected words, per-cycle compare.
module tb_fifo_stream_reader;
  localparam int unsigned PKT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_WIDTH(16), .CNT_WIDTH(16)) bus ();

  fifo_stream_reader #(.DATA_WIDTH(16), .PKT_LEN(PKT), .CNT_WIDTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_assert++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // FIFO model: one word per accepted read, valid for the whole following cycle
  logic [15:0] mem_f [0:255];
  int unsigned wr_cnt = 0;
  int unsigned rd_idx = 0;
  assign bus.fifo_empty = (rd_idx == wr_cnt);

  always @(posedge clk)
    if (bus.fifo_read && !bus.fifo_empty) begin
      bus.fifo_data <= mem_f[rd_idx[7:0]];
      rd_idx        <= rd_idx + 1;
    end

  task automatic load(input int unsigned a, input int unsigned b);
    for (int unsigned v = a; v <= b; v++) begin
      mem_f[wr_cnt[7:0]] = v[15:0];
      wr_cnt++;
    end
  endtask

  // Stream model: every word taken from the FIFO becomes visible one edge after it
  // arrives, leaves in order on a handshake, and is forgotten on reset.
  typedef struct {
    logic [15:0] data;
    int unsigned tag;
  } ent_t;
  ent_t        exp_q[$];
  logic [15:0] log_q[$];
  int unsigned cyc       = 0;
  int unsigned delivered = 0;

  function automatic bit m_valid();
    return (exp_q.size() > 0) && (exp_q[0].tag < cyc);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      delivered = 0;
    end else begin
      if (m_valid() && bus.out_ready) begin
        log_q.push_back(exp_q[0].data);
        void'(exp_q.pop_front());
        delivered++;
      end
      cyc++;
      if (bus.fifo_read && !bus.fifo_empty)
        exp_q.push_back('{data: mem_f[rd_idx[7:0]], tag: cyc});
    end
  end

  always @(negedge clk) begin
    bit          ev;
    bit          ep;
    int unsigned nbuf;
    int unsigned ninf;
    if (!rst) begin
      chk("rst_valid", {31'd0, bus.out_valid}, 0);
      chk("rst_data", {16'd0, bus.out_data}, 0);
      chk("rst_last", {31'd0, bus.out_last}, 0);
      chk("rst_cnt", {16'd0, bus.pkt_count}, 0);
      chk("rst_read", {31'd0, bus.fifo_read}, 0);
    end else begin
      ev   = m_valid();
      ep   = ev && bus.out_ready;
      nbuf = 0;
      ninf = 0;
      foreach (exp_q[i]) begin
        if (exp_q[i].tag < cyc) nbuf++;
        else ninf++;
      end
      chk("valid", {31'd0, bus.out_valid}, {31'd0, ev});
      if (ev) chk("data", {16'd0, bus.out_data}, {16'd0, exp_q[0].data});
      chk("last", {31'd0, bus.out_last},
          {31'd0, ev && ((delivered % PKT) == PKT - 1)});
      chk("pkt_count", {16'd0, bus.pkt_count}, (delivered / PKT) & 32'hFFFF);
      chk("fifo_read", {31'd0, bus.fifo_read},
          {31'd0, bus.en && !bus.fifo_empty && (nbuf + ninf < 2 + ep)});
      chk("occ_bound", {31'd0, exp_q.size() <= 2}, 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_order(input string name, input int unsigned n);
    chk({name, "_len"}, log_q.size(), n);
    for (int unsigned i = 0; i < n; i++)
      chk(name, (i < log_q.size()) ? {16'd0, log_q[i]} : 32'hFFFF_FFFF, i + 1);
  endtask

  task automatic poll_log(input int unsigned n);
    for (int i = 0; i < 200 && log_q.size() < n; i++) tick();
    chk("poll_timeout", {31'd0, log_q.size() >= n}, 1);
  endtask

  initial begin
    int rd_cnt;
    int first_rd;
    int first_val;
    int last_rd;
    int last_val;
    int val_cnt;
    logic saw8_last;
    logic [15:0] head_val;

    rst           = 1'b0;
    bus.en        = 1'b1;
    bus.out_ready = 1'b1;

    // 1: reset values, then release with the FIFO empty
    repeat (3) tick();
    chk("t1_valid", {31'd0, bus.out_valid}, 0);
    chk("t1_read", {31'd0, bus.fifo_read}, 0);
    rst = 1'b1;
    repeat (3) tick();
    chk("t1_noread", {31'd0, bus.fifo_read}, 0);

    // 2: continuous stream
    log_q.delete();
    load(1, 32);
    #1;
    rd_cnt = 0; val_cnt = 0; first_rd = -1; first_val = -1; last_rd = -1; last_val = -1;
    for (int i = 0; i < 50; i++) begin
      if (bus.fifo_read) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = i;
        last_rd = i;
      end
      if (bus.out_valid) begin
        val_cnt++;
        if (first_val < 0) first_val = i;
        last_val = i;
      end
      tick();
      #1;
    end
    chk("t2_reads", rd_cnt, 32);
    chk("t2_read_span", last_rd - first_rd, 31);
    chk("t2_latency", first_val - first_rd, 2);
    chk("t2_valids", val_cnt, 32);
    chk("t2_valid_span", last_val - first_val, 31);
    chk("t2_pkts", {16'd0, bus.pkt_count}, 8);
    chk("t2_idle_read", {31'd0, bus.fifo_read}, 0);
    check_order("t2_order", 32);

    // 3: stall
    tick();
    log_q.delete();
    bus.out_ready = 1'b0;
    load(1, 32);
    #1;
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.fifo_read) rd_cnt++;
      if (bus.out_valid) chk("t3_hold", {16'd0, bus.out_data}, 1);
      tick();
    end
    chk("t3_reads", rd_cnt, 2);
    chk("t3_data", {16'd0, bus.out_data}, 1);
    bus.out_ready = 1'b1;
    repeat (50) tick();
    check_order("t3_order", 32);

    // 4: toggling backpressure with a mid-run refill
    log_q.delete();
    load(1, 16);
    for (int i = 0; i < 80; i++) begin
      tick();
      bus.out_ready = ~bus.out_ready;
      if (i == 20) load(17, 32);
    end
    bus.out_ready = 1'b1;
    repeat (20) tick();
    check_order("t4_order", 32);

    // 5: enable gating after word 5
    log_q.delete();
    load(1, 20);
    poll_log(5);
    bus.en = 1'b0;
    rd_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.fifo_read) rd_cnt++;
    end
    chk("t5_reads", rd_cnt, 0);
    chk("t5_valid", {31'd0, bus.out_valid}, 0);
    check_order("t5_drain", 7);
    bus.en = 1'b1;
    saw8_last = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_valid && bus.out_data == 16'd8) saw8_last = bus.out_last;
    end
    chk("t5_last8", {31'd0, saw8_last}, 1);
    check_order("t5_order", 20);

    // 6: asynchronous reset between edges after word 10
    log_q.delete();
    load(1, 30);
    poll_log(10);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_valid", {31'd0, bus.out_valid}, 0);
    chk("t6_data", {16'd0, bus.out_data}, 0);
    chk("t6_last", {31'd0, bus.out_last}, 0);
    chk("t6_cnt", {16'd0, bus.pkt_count}, 0);
    chk("t6_read", {31'd0, bus.fifo_read}, 0);
    repeat (2) tick();
    head_val = mem_f[rd_idx[7:0]];
    chk("t6_head", {16'd0, head_val}, 13);
    rst = 1'b1;
    repeat (40) tick();
    chk("t6_len", log_q.size(), 28);
    chk("t6_resume", (log_q.size() > 10) ? {16'd0, log_q[10]} : 32'hFFFF_FFFF, 13);
    chk("t6_pkts", {16'd0, bus.pkt_count}, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
